// File: rtl/inv_zzscan.sv
// inv_zzscan -- inverse zigzag scan with optional dequantization.
//
// Coefficients arrive one per handshake in JPEG zigzag order and are written
// to raster positions in one of two 64x8 ping-pong banks. A full bank is
// drained as eight registered raster rows. While one bank drains, the other
// bank can fill.
//
// Build option: define INV_ZZSCAN_DEQUANT_EN to multiply each coefficient by
// the JPEG Annex K luminance/chrominance quantizer and saturate the result to
// 12 bits. Without it, each output is the coefficient sign-extended to 12 bits
// and lum_sel is ignored.
//
// Ports:
//   clk        rising-edge clock
//   nrst       asynchronous active-low reset
//   in_valid   coefficient present on coef_in
//   coef_in    signed 8-bit coefficient, zigzag order
//   lum_sel    1 = luminance table, 0 = chrominance (sampled at k=0 only)
//   in_ready   block can accept a coefficient
//   out_ready  downstream accepts the current row
//   out_valid  out0..out7 / out_row hold a valid row
//   out0..out7 signed 12-bit raster row, columns 0..7
//   out_row    row index 0..7

module inv_zzscan (
    input  logic        clk,
    input  logic        nrst,
    input  logic        in_valid,
    input  logic [7:0]  coef_in,
    input  logic        lum_sel,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [11:0] out0,
    output logic [11:0] out1,
    output logic [11:0] out2,
    output logic [11:0] out3,
    output logic [11:0] out4,
    output logic [11:0] out5,
    output logic [11:0] out6,
    output logic [11:0] out7,
    output logic [2:0]  out_row
);

    // Raster position of the k-th zigzag coefficient.
    localparam logic [5:0] ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [7:0]  bank0 [64];
    logic [7:0]  bank1 [64];

    logic [5:0]  k;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  full;

    logic        in_fire;
    logic        out_fire;
    logic        row_last;
    logic        blk_done;
    logic [1:0]  full_nxt;
    logic        rd_nxt;

    logic        load_en;
    logic        load_bank;
    logic [2:0]  load_row;
    logic        valid_nxt;

    logic [7:0]  row_coef [8];
    logic [11:0] row_out [8];

    assign in_ready = ~full[wr_ptr];
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign row_last = out_fire & (out_row == 3'd7);
    assign blk_done = in_fire & (k == 6'd63);

    // Clear first, then set: a bank that fills in the same cycle its flag is
    // being cleared ends up full.
    always_comb begin
        full_nxt = full;
        if (row_last) begin
            full_nxt[rd_ptr] = 1'b0;
        end
        if (blk_done) begin
            full_nxt[wr_ptr] = 1'b1;
        end
    end

    assign rd_nxt = row_last ? ~rd_ptr : rd_ptr;

    // Output row sequencing. When the last row of a bank is accepted, the
    // other bank's row 0 is loaded on the same edge if that bank is full or
    // becomes full on this edge, so back-to-back blocks drain without a
    // bubble. Row 0 never contains raster position 63, so a bank completing
    // on this very edge is safe to read for row 0. From idle, the registered
    // full flag is used, giving one cycle between the k=63 handshake and
    // out_valid.
    always_comb begin
        load_en   = 1'b0;
        load_bank = rd_ptr;
        load_row  = 3'd0;
        valid_nxt = out_valid;
        if (!out_valid || out_fire) begin
            if (out_fire && !row_last) begin
                load_en   = 1'b1;
                load_row  = out_row + 3'd1;
                valid_nxt = 1'b1;
            end else if (row_last ? full_nxt[rd_nxt] : full[rd_ptr]) begin
                load_en   = 1'b1;
                load_bank = rd_nxt;
                valid_nxt = 1'b1;
            end else begin
                valid_nxt = 1'b0;
            end
        end
    end

    // Bank storage has no reset; stale contents are never read because a
    // bank is only drained after all 64 positions have been rewritten.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (wr_ptr) begin
                bank1[ZZ[k]] <= coef_in;
            end else begin
                bank0[ZZ[k]] <= coef_in;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 8; c++) begin
            row_coef[c] = load_bank ? bank1[{load_row, 3'(c)}]
                                    : bank0[{load_row, 3'(c)}];
        end
    end

`ifdef INV_ZZSCAN_DEQUANT_EN
    localparam logic [7:0] Q_LUM [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    localparam logic [7:0] Q_CHR [64] = '{
        17,  18,  24,  47,  99,  99,  99,  99,
        18,  21,  26,  66,  99,  99,  99,  99,
        24,  26,  56,  99,  99,  99,  99,  99,
        47,  66,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99
    };

    logic [1:0] lum;
    logic       row_lum;

    // Table choice is captured per bank with the first coefficient.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lum <= 2'b00;
        end else if (in_fire && k == 6'd0) begin
            lum[wr_ptr] <= lum_sel;
        end
    end

    assign row_lum = lum[load_bank];

    // 8-bit signed times 8-bit unsigned fits in 17 bits signed.
    function automatic logic [11:0] dequant(input logic [7:0] coef,
                                            input logic [7:0] q);
        logic signed [16:0] prod;
        prod = $signed({{9{coef[7]}}, coef}) * $signed({9'd0, q});
        if (prod > 17'sd2047) begin
            return 12'h7FF;
        end else if (prod < -17'sd2048) begin
            return 12'h800;
        end else begin
            return prod[11:0];
        end
    endfunction

    always_comb begin
        for (int c = 0; c < 8; c++) begin
            row_out[c] = dequant(row_coef[c],
                                 row_lum ? Q_LUM[{load_row, 3'(c)}]
                                         : Q_CHR[{load_row, 3'(c)}]);
        end
    end
`else
    logic unused_lum;
    assign unused_lum = lum_sel;

    always_comb begin
        for (int c = 0; c < 8; c++) begin
            row_out[c] = {{4{row_coef[c][7]}}, row_coef[c]};
        end
    end
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            k         <= 6'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            full      <= 2'b00;
            out_valid <= 1'b0;
            out_row   <= 3'd0;
            out0      <= 12'd0;
            out1      <= 12'd0;
            out2      <= 12'd0;
            out3      <= 12'd0;
            out4      <= 12'd0;
            out5      <= 12'd0;
            out6      <= 12'd0;
            out7      <= 12'd0;
        end else begin
            full      <= full_nxt;
            rd_ptr    <= rd_nxt;
            out_valid <= valid_nxt;
            if (in_fire) begin
                // k wraps from 63 back to 0 by itself.
                k <= k + 6'd1;
                if (k == 6'd63) begin
                    wr_ptr <= ~wr_ptr;
                end
            end
            if (load_en) begin
                out_row <= load_row;
                out0    <= row_out[0];
                out1    <= row_out[1];
                out2    <= row_out[2];
                out3    <= row_out[3];
                out4    <= row_out[4];
                out5    <= row_out[5];
                out6    <= row_out[6];
                out7    <= row_out[7];
            end
        end
    end

endmodule

// File: tb/tb_inv_zzscan.sv
module tb_inv_zzscan;

    logic        clk = 1'b0;
    logic        nrst;
    logic        in_valid;
    logic [7:0]  coef_in;
    logic        lum_sel;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [11:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [2:0]  out_row;

    inv_zzscan dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .coef_in   (coef_in),
        .lum_sel   (lum_sel),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7),
        .out_row   (out_row)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry: {row[2:0], col7..col0 (12 bits each)}.
    logic [98:0] exp_q [$];

    int   zz [64];
    int   blk [64];
    int   m_blk [64];
    int   m_k;
    logic m_lum;

`ifdef INV_ZZSCAN_DEQUANT_EN
    int q_lum [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99};
    int q_chr [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99};
`endif

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Zigzag order derived by walking the anti-diagonals.
    function automatic void build_zz();
        int idx = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 8) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz[idx] = r * 8 + (s - r);
                    idx++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz[idx] = r * 8 + (s - r);
                    idx++;
                end
            end
        end
    endfunction

    function automatic int exp_val(input int coef, input int pos, input logic lum);
`ifdef INV_ZZSCAN_DEQUANT_EN
        int p;
        p = coef * (lum ? q_lum[pos] : q_chr[pos]);
        if (p > 2047)  p = 2047;
        if (p < -2048) p = -2048;
        return p;
`else
        return coef;
`endif
    endfunction

    function automatic int col(input int c);
        case (c)
            0: return $signed(out0);
            1: return $signed(out1);
            2: return $signed(out2);
            3: return $signed(out3);
            4: return $signed(out4);
            5: return $signed(out5);
            6: return $signed(out6);
            default: return $signed(out7);
        endcase
    endfunction

    task automatic model_accept(input int c, input logic l);
        if (m_k == 0) m_lum = l;
        m_blk[zz[m_k]] = c;
        if (m_k == 63) begin
            for (int r = 0; r < 8; r++) begin
                logic [98:0] w;
                w = '0;
                w[98:96] = 3'(r);
                for (int cc = 0; cc < 8; cc++) begin
                    w[cc*12 +: 12] = 12'(exp_val(m_blk[r*8+cc], r*8+cc, m_lum));
                end
                exp_q.push_back(w);
            end
            m_k = 0;
        end else begin
            m_k++;
        end
    endtask

    // Offer one coefficient until accepted (bounded).
    task automatic put(input int c, input logic l);
        bit r = 1'b0;
        int tries = 0;
        in_valid = 1'b1;
        coef_in  = 8'(c);
        lum_sel  = l;
        while (!r && tries < 200) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        chk("in_accept", int'(r), 1);
        if (r) model_accept(c, l);
    endtask

    // lum_sel is flipped after k=0 to confirm it is only sampled at k=0.
    task automatic send_blk(input logic l, input int n);
        for (int k = 0; k < n; k++) begin
            put(blk[k], (k == 0) ? l : ~l);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 600 && (exp_q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic check_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_row", out_row, 0);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("rst_out%0d", c), col(c), 0);
        end
    endtask

    // Scoreboard consumer: compare each row at its handshake.
    always @(negedge clk) begin
        if (nrst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("row_expected", exp_q.size(), 1);
            end else begin
                logic [98:0] w;
                w = exp_q.pop_front();
                chk("out_row", out_row, int'(w[98:96]));
                for (int c = 0; c < 8; c++) begin
                    chk($sformatf("row%0d_out%0d", w[98:96], c), col(c),
                        $signed(w[c*12 +: 12]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        build_zz();
        nrst      = 1'b0;
        in_valid  = 1'b0;
        coef_in   = 8'd0;
        lum_sel   = 1'b0;
        out_ready = 1'b1;
        m_k       = 0;
        m_lum     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Ramp k=0..63, plus first-row latency from idle.
        for (int k = 0; k < 64; k++) blk[k] = k;
        send_blk(1'b1, 64);
        chk("lat_valid_edge0", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_valid_edge1", out_valid, 1);
        wait_drain();

        // DC only, both tables.
        for (int k = 0; k < 64; k++) blk[k] = 0;
        blk[0] = 2;
        send_blk(1'b1, 64);
        wait_drain();
        send_blk(1'b0, 64);
        wait_drain();

        // Saturation corners.
        for (int k = 0; k < 64; k++) blk[k] = 0;
        blk[63] = 127;
        blk[1]  = -3;
        send_blk(1'b1, 64);
        wait_drain();
        blk[63] = -128;
        send_blk(1'b1, 64);
        wait_drain();

        // Random data with random back-pressure.
        for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(0, 255)) - 128;
        fork
            send_blk(1'($urandom_range(0, 1)), 64);
            begin
                repeat (150) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Back-pressure: two blocks fill, further coefficients rejected.
        out_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(0, 255)) - 128;
            send_blk(1'b1, 64);
        end
        in_valid = 1'b1;
        coef_in  = 8'h55;
        repeat (2) begin
            @(negedge clk);
            chk("in_ready_full", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_row", out_row, 0);
            chk("stall_out0", $signed(out0), $signed(exp_q[0][11:0]));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("stream_valid_%0d", i), out_valid, 1);
        end
        wait_drain();

        // Row 7 of bank 0 accepted on the same edge as k=63 of bank 1.
        out_ready = 1'b0;
        for (int k = 0; k < 64; k++) blk[k] = k - 32;
        send_blk(1'b0, 64);
        for (int k = 0; k < 64; k++) blk[k] = 100 - k;
        send_blk(1'b1, 63);
        out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        put(blk[63], 1'b0);
        chk("sim_out_valid", out_valid, 1);
        chk("sim_out_row", out_row, 0);
        chk("sim_in_ready", in_ready, 1);
        wait_drain();

        // Reset mid-drain and mid-block, then a clean block from k=0.
        out_ready = 1'b0;
        for (int k = 0; k < 64; k++) blk[k] = (k % 2 == 0) ? 7 : -9;
        send_blk(1'b1, 64);
        send_blk(1'b1, 20);
        nrst = 1'b0;
        #1;
        check_reset();
        exp_q.delete();
        m_k = 0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) blk[k] = 63 - k;
        send_blk(1'b1, 64);
        wait_drain();

        chk("q_left", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_zzscan.md
INV_ZZSCAN -- requirements
Module: inv_zzscan

Interface
REQ-001 The module SHALL have one clock and asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port in_valid, input, 1 bit: a coefficient is present on coef_in.
REQ-005 Port coef_in, input, 8 bits: signed two's-complement quantized coefficient, zigzag order.
REQ-006 Port lum_sel, input, 1 bit: 1 selects the luminance table, 0 selects the chrominance table.
REQ-007 Port in_ready, output, 1 bit: the block can accept a coefficient.
REQ-008 Port out_ready, input, 1 bit: the downstream IDCT accepts the current row.
REQ-009 Port out_valid, output, 1 bit: out0..out7 and out_row hold a valid row.
REQ-010 Ports out0..out7, output, 12 bits each: signed raster row, columns 0..7.
REQ-011 Port out_row, output, 3 bits: row index 0..7 of the current output.

Function
REQ-012 The input handshake SHALL complete on a rising edge when in_valid and in_ready are both 1.
REQ-013 The output handshake SHALL complete on a rising edge when out_valid and out_ready are both 1.
REQ-014 Storage SHALL be two 64x8 banks in ping-pong use, with a write-bank pointer, a read-bank pointer and one full flag per bank.
REQ-015 Accepted coefficient k (0..63) SHALL be written to raster position ZZ[k] of the write bank.
REQ-016 ZZ[k] SHALL be the standard JPEG zigzag map: ZZ[0..5]=0,1,8,16,9,2 and ZZ[63]=63.
REQ-017 lum_sel SHALL be latched per bank when k=0 is accepted and SHALL be ignored for k=1..63.
REQ-018 When k=63 is accepted, the module SHALL set that bank's full flag, toggle the write pointer and clear k to 0.
REQ-019 in_ready SHALL equal the inverse of the full flag of the current write bank.
REQ-020 While the read bank is full, the module SHALL output rows 0..7 in order on registered outputs.
REQ-021 The first out_valid SHALL rise one cycle after the k=63 handshake when no other bank is draining.
REQ-022 out0..out7, out_row and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 After row 7 is accepted, the module SHALL clear the read bank's full flag and toggle the read pointer.
REQ-024 If the other bank is already full when row 7 is accepted, row 0 of that bank SHALL appear on the next cycle with no bubble.
REQ-025 If row 7 of one bank and k=63 of the other bank are accepted in the same cycle, both flag updates SHALL take effect and no data SHALL be lost.
REQ-026 If a bank fills in the same cycle its full flag is being cleared, the set SHALL win.
REQ-027 When both banks are full, in_ready SHALL be 0, and coefficients offered while in_ready=0 SHALL not be stored.
REQ-028 Dequantization SHALL compute coef times Q[raster position], with Q the standard JPEG Annex K luminance or chrominance table chosen by the latched lum_sel.
REQ-029 Reference table values: luminance Q[0]=16, Q[1]=11, Q[63]=99; chrominance Q[0]=17, Q[1]=18.
REQ-030 Dequantized products SHALL be computed signed at 15 bits or wider and saturated to the range -2048..2047.

Reset
REQ-031 While nrst=0, the module SHALL force out_valid=0, in_ready=1, out0..out7=0, out_row=0, both full flags=0, both bank pointers=0 and k=0.
REQ-032 Reset asserted mid-block or mid-drain SHALL discard all partial data; bank contents need not be cleared.
REQ-033 The first handshake after nrst rises SHALL be treated as k=0.

Configuration
REQ-034 The macro SHALL be named INV_ZZSCAN_DEQUANT_EN.
REQ-035 With INV_ZZSCAN_DEQUANT_EN defined, the module SHALL apply the dequantization and saturation of REQ-028 to REQ-030.
REQ-036 Without INV_ZZSCAN_DEQUANT_EN, each output SHALL be the 8-bit coefficient sign-extended to 12 bits, with no multiplier or table logic synthesized.
REQ-037 lum_sel SHALL be unused when INV_ZZSCAN_DEQUANT_EN is undefined.
REQ-038 Latency and handshake behaviour SHALL be identical with and without INV_ZZSCAN_DEQUANT_EN.

Verification
REQ-039 Reset scenario: pulse nrst low mid-block -> out_valid=0, in_ready=1 and all outputs 0; the next block must decode correctly from k=0.
REQ-040 Zigzag map, macro off: feed coef_in=k for k=0..63 with out_ready=1 -> row0 = 0,1,5,6,14,15,27,28; row1 = 2,4,7,13,16,26,29,42; row7 = 35,36,48,49,57,58,62,63.
REQ-041 Dequantization, macro on: DC=2 with all other coefficients 0.
- lum_sel=1 -> row0 out0=32, all other outputs 0.
- lum_sel=0 -> row0 out0=34.
REQ-042 Saturation, macro on, lum_sel=1:
- k=63 coef=127 -> row7 out7=2047.
- k=63 coef=-128 -> row7 out7=-2048.
- k=1 coef=-3 -> row0 out1=-33.
REQ-043 Back-pressure: hold out_ready=0 and feed 130 coefficients -> 128 accepted, then in_ready=0 and coefficients 129-130 rejected.
- On releasing out_ready, rows stream for bank 0 then bank 1 with no bubble.
REQ-044 Simultaneous-event case: align the bank 0 row-7 handshake with the bank 1 k=63 handshake -> bank 1 row 0 valid on the next cycle and in_ready=1.
